// File: rtl/boot_load_ctrl.sv
// ---------------------------------------------------------------------------
// boot_load_ctrl
//
// Sequences the single-cycle RISC-V core. While the core is held in reset,
// a program image is streamed from the host port into the instruction memory.
// The core is then released and its PC is watched. Once the program parks in
// a self-loop ("j ."), the core is put back into reset.
//
// Ports
//   clk          in   1   clock, rising edge
//   reset_n      in   1   asynchronous, active-low reset
//   start        in   1   begin a load (taken in IDLE, RUN, HALT)
//   ld_valid     in   1   host word valid
//   ld_data      in   32  host instruction word
//   ld_last      in   1   final word of the image (qualified by ld_valid)
//   ld_ready     out  1   controller accepts a word this cycle
//   imem_we      out  1   instruction memory write enable
//   imem_addr    out  32  word-aligned byte address of the write
//   imem_wdata   out  32  instruction memory write data
//   pc           in   32  core program counter
//   cpu_reset    out  1   active-high reset to the core
//   busy         out  1   state is LOAD, HOLD or RUN
//   halted       out  1   self-loop detected (sticky until next start)
//   load_err     out  1   image overflowed MAX_WORDS (sticky until next start)
//   cycle_count  out  32  cycles spent in RUN, saturating
//   dbg_state    out  3   current FSM state encoding
//
// Host handshake: a word moves when ld_valid and ld_ready are both high at a
// rising clock edge. ld_ready is a registered state decode (high only in
// LOAD); ld_valid may rise or fall in any cycle and the host must hold
// ld_data/ld_last stable while ld_valid is high.
// ---------------------------------------------------------------------------
module boot_load_ctrl #(
    parameter int MAX_WORDS   = 64,
    parameter int RST_CYCLES  = 2,
    parameter int HALT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic [31:0] pc,
    output logic        cpu_reset,
    output logic        busy,
    output logic        halted,
    output logic        load_err,
    output logic [31:0] cycle_count,
    output logic [2:0]  dbg_state
);

    localparam int IW = $clog2(MAX_WORDS + 1);
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(HALT_CYCLES);

    localparam logic [IW-1:0] LAST_IDX   = IW'(MAX_WORDS - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_CYCLES - 1);
    // The halt fires on the match that lifts stall_cnt to HALT_CYCLES-1.
    localparam logic [SW-1:0] STALL_TRIG = SW'(HALT_CYCLES - 2);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_HALT = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   word_idx_q, word_idx_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
    logic [31:0]     pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            halted_q, halted_d;
    logic            load_err_q, load_err_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic            ld_ready_q, ld_ready_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic            busy_q, busy_d;

    logic            transfer;
    logic            pc_match;
    logic            start_load;

    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        hold_cnt_d    = '0;
        stall_cnt_d   = '0;
        pc_d          = pc_q;
        pc_valid_d    = 1'b0;
        halted_d      = halted_q;
        load_err_d    = load_err_q;
        cycle_count_d = cycle_count_q;
        start_load    = 1'b0;

        transfer = ld_valid & ld_ready_q;
        // pc_q is only meaningful after one full RUN cycle has captured it.
        pc_match = pc_valid_q && (pc == pc_q);

        case (state_q)
            ST_IDLE, ST_HALT: begin
                start_load = start;
            end
            ST_LOAD: begin
                if (transfer) begin
                    word_idx_d = word_idx_q + IW'(1);
                    if (ld_last) begin
                        state_d = ST_HOLD;
                    end else if (word_idx_q == LAST_IDX) begin
                        // Image does not fit: abandon it, core stays in reset.
                        state_d    = ST_IDLE;
                        load_err_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_RUN: begin
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
                pc_d       = pc;
                pc_valid_d = 1'b1;
                if (pc_match) begin
                    stall_cnt_d = stall_cnt_q + SW'(1);
                end
                // start takes priority over a coincident halt.
                if (start) begin
                    start_load = 1'b1;
                end else if (pc_match && (stall_cnt_q == STALL_TRIG)) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_load) begin
            state_d       = ST_LOAD;
            word_idx_d    = '0;
            halted_d      = 1'b0;
            load_err_d    = 1'b0;
            cycle_count_d = '0;
            stall_cnt_d   = '0;
            pc_valid_d    = 1'b0;
        end

        ld_ready_d  = (state_d == ST_LOAD);
        cpu_reset_d = (state_d != ST_RUN);
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_HOLD) || (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            word_idx_q    <= '0;
            hold_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            pc_q          <= '0;
            pc_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            load_err_q    <= 1'b0;
            cycle_count_q <= '0;
            ld_ready_q    <= 1'b0;
            cpu_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            hold_cnt_q    <= hold_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            pc_q          <= pc_d;
            pc_valid_q    <= pc_valid_d;
            halted_q      <= halted_d;
            load_err_q    <= load_err_d;
            cycle_count_q <= cycle_count_d;
            ld_ready_q    <= ld_ready_d;
            cpu_reset_q   <= cpu_reset_d;
            busy_q        <= busy_d;
        end
    end

    assign ld_ready    = ld_ready_q;
    assign imem_we     = transfer;
    assign imem_addr   = {{(30 - IW){1'b0}}, word_idx_q, 2'b00};
    assign imem_wdata  = ld_data;
    assign cpu_reset   = cpu_reset_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign load_err    = load_err_q;
    assign cycle_count = cycle_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boot_load_ctrl
//
// Drives randomized program loads and PC traces into boot_load_ctrl. The main
// process pushes expected memory writes and expected per-cycle status into
// queues; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_boot_load_ctrl;

    localparam int MAXW  = 8;
    localparam int RSTC  = 2;
    localparam int HALTC = 4;

    typedef struct packed {
        logic        cr;
        logic        rdy;
        logic        busy;
        logic        hlt;
        logic        err;
        logic [31:0] cc;
    } st_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic [31:0] pc = '0;

    logic        ld_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        halted;
    logic        load_err;
    logic [31:0] cycle_count;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    boot_load_ctrl #(
        .MAX_WORDS   (MAXW),
        .RST_CYCLES  (RSTC),
        .HALT_CYCLES (HALTC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .pc          (pc),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .halted      (halted),
        .load_err    (load_err),
        .cycle_count (cycle_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];      // {addr, data} of each expected write
    st_t         exp_st_q[$];   // expected status, one entry per cycle
    logic [31:0] dir_pc[$];     // optional directed PC trace
    int          n_vec = 0;
    int          n_err = 0;
    logic        finish_req = 1'b0;
    logic        final_done = 1'b0;

    // reference model: sticky flags and RUN cycle count
    logic        m_halted = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_cc = '0;

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] w;
        st_t         s;
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write @%0t: addr=%h data=%h, expected no write",
                         $time, imem_addr, imem_wdata);
            end else begin
                w = exp_q.pop_front();
                chk("imem_addr", imem_addr, w[63:32]);
                chk("imem_wdata", imem_wdata, w[31:0]);
            end
        end
        if (exp_st_q.size() != 0) begin
            s = exp_st_q.pop_front();
            chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, s.cr});
            chk("ld_ready", {31'd0, ld_ready}, {31'd0, s.rdy});
            chk("busy", {31'd0, busy}, {31'd0, s.busy});
            chk("halted", {31'd0, halted}, {31'd0, s.hlt});
            chk("load_err", {31'd0, load_err}, {31'd0, s.err});
            chk("cycle_count", cycle_count, s.cc);
        end
        if (finish_req && !final_done) begin
            chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
            final_done <= 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_st(input logic cr, input logic rdy, input logic bsy);
        st_t s;
        s.cr   = cr;
        s.rdy  = rdy;
        s.busy = bsy;
        s.hlt  = m_halted;
        s.err  = m_err;
        s.cc   = m_cc;
        exp_st_q.push_back(s);
    endtask

    task automatic junk();
        ld_valid = 1'($urandom_range(0, 1));
        ld_data  = $urandom;
        ld_last  = 1'($urandom_range(0, 1));
    endtask

    // IDLE or HALT: host traffic must be ignored, status frozen.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            junk();
            pc = $urandom;
            tick();
            push_st(1'b1, 1'b0, 1'b0);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic pulse_start();
        ld_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_cc     = '0;
        push_st(1'b1, 1'b1, 1'b1);
    endtask

    // Streams n words; to_hold reports whether the image was closed by ld_last.
    task automatic load_words(input int n, input bit use_last, output bit to_hold);
        int          gaps;
        logic [31:0] a;
        to_hold = 1'b0;
        for (int i = 0; i < n; i++) begin
            gaps = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                ld_valid = 1'b0;
                ld_data  = $urandom;
                ld_last  = 1'($urandom_range(0, 1));
                start    = 1'($urandom_range(0, 1));
                tick();
                start = 1'b0;
                push_st(1'b1, 1'b1, 1'b1);
            end
            ld_valid = 1'b1;
            ld_data  = $urandom;
            ld_last  = use_last && (i == n - 1);
            start    = 1'($urandom_range(0, 1));
            a        = 32'(i * 4);
            exp_q.push_back({a, ld_data});
            tick();
            start    = 1'b0;
            ld_valid = 1'b0;
            if (ld_last) begin
                to_hold = 1'b1;
                push_st(1'b1, 1'b0, 1'b1);
                break;
            end else if (i == MAXW - 1) begin
                m_err = 1'b1;
                push_st(1'b1, 1'b0, 1'b0);
                break;
            end else begin
                push_st(1'b1, 1'b1, 1'b1);
            end
        end
        ld_last = 1'b0;
    endtask

    // Core stays in reset for RSTC cycles after the last word, then runs.
    task automatic hold_phase();
        for (int r = 1; r < RSTC; r++) begin
            start    = 1'($urandom_range(0, 1));
            ld_valid = 1'($urandom_range(0, 1));
            tick();
            push_st(1'b1, 1'b0, 1'b1);
        end
        start    = 1'($urandom_range(0, 1));
        ld_valid = 1'($urandom_range(0, 1));
        tick();
        start    = 1'b0;
        ld_valid = 1'b0;
        push_st(1'b0, 1'b0, 1'b1);
    endtask

    // Presents one PC per RUN cycle. Halt is predicted when the same PC has
    // been seen HALTC cycles in a row. Returns restarted=1 if a start was
    // issued (at cycle start_at, or on the halting cycle if start_on_halt).
    task automatic run_prog(input int start_at, input bit start_on_halt, output bit restarted);
        int          park_at;
        int          runlen;
        logic [31:0] prev;
        logic [31:0] v;
        park_at   = int'($urandom_range(2, 20));
        runlen    = 0;
        prev      = '0;
        restarted = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (dir_pc.size() != 0) begin
                v = dir_pc.pop_front();
            end else if (k >= park_at) begin
                v = prev;
            end else if (k > 0 && $urandom_range(0, 3) == 0) begin
                v = prev;
            end else if ($urandom_range(0, 1) == 0) begin
                v = prev + 32'd4;
            end else begin
                v = $urandom & 32'hFFFF_FFFC;
            end
            runlen = (k > 0 && v == prev) ? runlen + 1 : 1;
            prev   = v;
            pc     = v;
            junk();
            if (k == start_at || (start_on_halt && runlen == HALTC)) begin
                start = 1'b1;
                tick();
                start    = 1'b0;
                ld_valid = 1'b0;
                ld_last  = 1'b0;
                m_cc     = '0;
                m_halted = 1'b0;
                m_err    = 1'b0;
                push_st(1'b1, 1'b1, 1'b1);
                restarted = 1'b1;
                return;
            end
            tick();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            m_cc     = m_cc + 32'd1;
            if (runlen == HALTC) begin
                m_halted = 1'b1;
                push_st(1'b1, 1'b0, 1'b0);
                return;
            end
            push_st(1'b0, 1'b0, 1'b1);
        end
    endtask

    // Asynchronous reset in the middle of a cycle: this cycle's status must
    // already show reset values at the following negedge.
    task automatic async_reset();
        void'(exp_st_q.pop_back());
        reset_n  = 1'b0;
        m_halted = 1'b0;
        m_err    = 1'b0;
        m_cc     = '0;
        ld_valid = 1'b1;
        ld_data  = $urandom;
        ld_last  = 1'($urandom_range(0, 1));
        push_st(1'b1, 1'b0, 1'b0);
        tick();
        reset_n  = 1'b1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        push_st(1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        bit rs;
        int n;
        int sa;

        tick();
        push_st(1'b1, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        push_st(1'b1, 1'b0, 1'b0);
        idle_cycles(3);

        // three-word image, then PC 0,4,8 and parked at 0x10
        pulse_start();
        load_words(3, 1'b1, ok);
        hold_phase();
        dir_pc.push_back(32'h0);
        dir_pc.push_back(32'h4);
        dir_pc.push_back(32'h8);
        for (int i = 0; i < HALTC; i++) dir_pc.push_back(32'h10);
        run_prog(-1, 1'b0, rs);
        idle_cycles(3);

        // overflow: MAXW words, no ld_last
        pulse_start();
        load_words(MAXW, 1'b0, ok);
        idle_cycles(3);

        // full-depth image closed on the last slot
        pulse_start();
        load_words(MAXW, 1'b1, ok);
        hold_phase();
        run_prog(-1, 1'b0, rs);
        idle_cycles(2);

        // start mid-RUN reloads from address 0
        pulse_start();
        load_words(2, 1'b1, ok);
        hold_phase();
        run_prog(3, 1'b0, rs);
        load_words(4, 1'b1, ok);
        hold_phase();
        run_prog(-1, 1'b0, rs);
        idle_cycles(2);

        // start coincident with the halt condition
        pulse_start();
        load_words(1, 1'b1, ok);
        hold_phase();
        run_prog(-1, 1'b1, rs);
        load_words(2, 1'b1, ok);
        hold_phase();
        run_prog(-1, 1'b0, rs);
        idle_cycles(2);

        // asynchronous reset mid-LOAD, then reload; then reset while halted
        pulse_start();
        load_words(2, 1'b0, ok);
        async_reset();
        idle_cycles(2);
        pulse_start();
        load_words(3, 1'b1, ok);
        hold_phase();
        run_prog(-1, 1'b0, rs);
        async_reset();
        idle_cycles(2);

        // randomized sessions
        for (int it = 0; it < 20; it++) begin
            pulse_start();
            if ($urandom_range(0, 3) == 0) begin
                load_words(MAXW, 1'b0, ok);
            end else begin
                n = int'($urandom_range(1, MAXW));
                load_words(n, 1'b1, ok);
            end
            if (ok) begin
                hold_phase();
                sa = -1;
                if ($urandom_range(0, 3) == 0) sa = int'($urandom_range(0, 15));
                run_prog(sa, ($urandom_range(0, 3) == 0), rs);
                if (rs) begin
                    n = int'($urandom_range(1, MAXW));
                    load_words(n, 1'b1, ok);
                    hold_phase();
                    run_prog(-1, 1'b0, rs);
                end
            end
            idle_cycles(int'($urandom_range(1, 3)));
        end

        finish_req = 1'b1;
        tick();
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
